demux_5_reg: RTL and testbench

- Registered 1-to-5 stream demultiplexer; the distribution counterpart of the 5-way select mux in the RV32 datapath primitives.
- Accepts one data word plus a 3-bit destination select over a valid/ready handshake.
- Forwards the word to exactly one of five output channels through a single pipeline register stage.
- Used to route results or requests from one producer to one of five consumers, e.g. per-unit issue ports or peripheral request channels.

---
 rtl/demux_5_reg.sv | 128 ++++++++++++
 tb/tb_demux_5_reg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/demux_5_reg.sv
// demux_5_reg -- registered 1-to-5 stream demultiplexer.
//
// Accepts one word plus a 3-bit destination over a valid/ready handshake and
// forwards it to exactly one of five output channels through a single
// pipeline register. Selects 5..7 are consumed, dropped and counted.
//
// Parameters:
//   DW  data width of the input and of each output channel
//   EW  width of the saturating invalid-select error counter
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   input word valid
//   in_ready   block can accept the input word this cycle (combinational)
//   in_sel     destination, 0..4 select channels 1..5
//   in_data    input word
//   out_valid  per-channel valid, bit k is channel k+1, at most one bit set
//   out_ready  per-channel ready from the consumers
//   out_data   per-channel data, slice k is channel k+1
//   err_pulse  one-cycle pulse: an invalid-select word was accepted
//   err_cnt    saturating count of invalid-select words accepted
//
// Build option:
//   DEMUX5_ZERO_IDLE_EN  when defined, only the slice whose out_valid bit is
//                        set carries the held data; all other slices read 0.
//                        When undefined, every slice carries the held data.

module demux_5_reg #(
    parameter int DW = 32,
    parameter int EW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_sel,
    input  logic [DW-1:0]   in_data,
    output logic [4:0]      out_valid,
    input  logic [4:0]      out_ready,
    output logic [5*DW-1:0] out_data,
    output logic            err_pulse,
    output logic [EW-1:0]   err_cnt
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } entry_state_t;

    localparam logic [EW-1:0] ERR_MAX = '1;

    entry_state_t    state;
    entry_state_t    state_nxt;
    logic [DW-1:0]   data_q;
    logic [2:0]      dest_q;
    logic            drain;
    logic            accept;
    logic            sel_ok;
    logic            load;
    logic            drop;

    // Per-channel valid decode of the single held entry.
    always_comb begin
        out_valid = '0;
        for (int unsigned k = 0; k < 5; k++) begin
            out_valid[k] = (state == ST_FULL) && (dest_q == 3'(k));
        end
    end

    // Only the ready bit of the held destination can drain the entry.
    assign drain    = |(out_valid & out_ready);
    assign in_ready = (state == ST_EMPTY) || drain;
    assign accept   = in_valid && in_ready;
    assign sel_ok   = (in_sel <= 3'd4);
    assign load     = accept && sel_ok;
    assign drop     = accept && !sel_ok;

    // A load in the same cycle as a drain replaces the departing word, so
    // load takes priority over drain when deciding the next occupancy.
    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = ST_FULL;
        end else if (drain) begin
            state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            dest_q <= '0;
        end else if (load) begin
            data_q <= in_data;
            dest_q <= in_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= drop;
            if (drop && (err_cnt != ERR_MAX)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < 5; g++) begin : g_slice
`ifdef DEMUX5_ZERO_IDLE_EN
        assign out_data[g*DW +: DW] = out_valid[g] ? data_q : '0;
`else
        assign out_data[g*DW +: DW] = data_q;
`endif
    end

endmodule

// File: tb/tb_demux_5_reg.sv
// tb_demux_5_reg -- self-checking bench for demux_5_reg.
//
// A queue-based reference model holds accepted words in order; the head of
// the queue is what the DUT should be presenting. Directed scenarios are
// followed by a randomized run with occasional resets.

module tb_demux_5_reg;

    localparam int DW = 32;
    localparam int EW = 8;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_sel;
    logic [DW-1:0]   in_data;
    logic [4:0]      out_valid;
    logic [4:0]      out_ready;
    logic [5*DW-1:0] out_data;
    logic            err_pulse;
    logic [EW-1:0]   err_cnt;

    demux_5_reg #(.DW(DW), .EW(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    sel;
        logic [DW-1:0] data;
    } word_t;

    word_t         q[$];
    logic [DW-1:0] last_data;
    int            m_err;
    logic          m_pulse;
    int            n_checks;
    int            n_errors;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check all outputs against the model, then
    // advance the model by the handshake rules and move past the clock edge.
    task automatic step(input logic v, input logic [2:0] s, input logic [DW-1:0] d,
                        input logic [4:0] rdy, input logic r);
        logic            e_ready;
        logic [4:0]      e_valid;
        logic [5*DW-1:0] e_data;
        logic            drained;
        word_t           w;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = rdy;
        rst       = r;
        #1;
        e_valid = '0;
        if (q.size() != 0) e_valid[q[0].sel] = 1'b1;
        e_ready = (q.size() == 0) || rdy[q[0].sel];
        for (int k = 0; k < 5; k++) begin
`ifdef DEMUX5_ZERO_IDLE_EN
            e_data[k*DW +: DW] = e_valid[k] ? last_data : '0;
`else
            e_data[k*DW +: DW] = last_data;
`endif
        end
        check("in_ready", 192'(in_ready), 192'(e_ready));
        check("out_valid", 192'(out_valid), 192'(e_valid));
        check("out_data", 192'(out_data), 192'(e_data));
        check("err_pulse", 192'(err_pulse), 192'(m_pulse));
        check("err_cnt", 192'(err_cnt), 192'(m_err));
        if (r) begin
            q.delete();
            last_data = '0;
            m_err     = 0;
            m_pulse   = 1'b0;
        end else begin
            drained = (q.size() != 0) && rdy[q[0].sel];
            if (drained) void'(q.pop_front());
            m_pulse = 1'b0;
            if (v && e_ready) begin
                if (s <= 3'd4) begin
                    w.sel  = s;
                    w.data = d;
                    q.push_back(w);
                    last_data = d;
                end else begin
                    m_pulse = 1'b1;
                    if (m_err < (1 << EW) - 1) m_err++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        last_data = '0;
        m_err     = 0;
        m_pulse   = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        @(posedge clk);
        #1;
        q.delete();
        step(1'b0, 3'd0, '0, 5'b11111, 1'b1);

        // Single word to channel 3.
        step(1'b1, 3'd2, 32'hDEADBEEF, 5'b11111, 1'b0);
        check("single_valid", 192'(out_valid), 192'(5'b00100));
        check("single_data", 192'(out_data[2*DW +: DW]), 192'(32'hDEADBEEF));
        step(1'b0, 3'd0, '0, 5'b11111, 1'b0);
        check("single_gone", 192'(out_valid), 192'(5'b00000));

        // Back-to-back stream walking all channels.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 3'(i), 32'(i + 1), 5'b11111, 1'b0);
            check("walk_valid", 192'(out_valid), 192'(5'b00001 << i));
            check("walk_data", 192'(out_data[i*DW +: DW]), 192'(i + 1));
        end
        step(1'b0, 3'd0, '0, 5'b11111, 1'b0);

        // Backpressure on channel 2, then simultaneous drain and load.
        step(1'b1, 3'd1, 32'hA5A5A5A5, 5'b11111, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'd4, 32'd7, 5'b11101, 1'b0);
            check("bp_valid", 192'(out_valid), 192'(5'b00010));
            check("bp_data", 192'(out_data[1*DW +: DW]), 192'(32'hA5A5A5A5));
        end
        step(1'b1, 3'd4, 32'd7, 5'b11111, 1'b0);
        check("bp_swap_valid", 192'(out_valid), 192'(5'b10000));
        check("bp_swap_data", 192'(out_data[4*DW +: DW]), 192'(32'd7));
        step(1'b0, 3'd0, '0, 5'b11111, 1'b0);

        // Invalid select and saturation.
        step(1'b1, 3'd6, 32'h1234, 5'b11111, 1'b0);
        check("inv_pulse", 192'(err_pulse), 192'(1'b1));
        check("inv_cnt", 192'(err_cnt), 192'(1));
        check("inv_novalid", 192'(out_valid), 192'(5'b00000));
        step(1'b0, 3'd0, '0, 5'b11111, 1'b0);
        check("inv_pulse_end", 192'(err_pulse), 192'(1'b0));
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 3'(5 + (i % 3)), 32'(i), 5'b11111, 1'b0);
        end
        check("err_saturate", 192'(err_cnt), 192'(255));

        // Reset with a word held.
        step(1'b1, 3'd3, 32'hCAFE0003, 5'b00000, 1'b0);
        step(1'b0, 3'd0, '0, 5'b00000, 1'b0);
        step(1'b0, 3'd0, '0, 5'b00000, 1'b1);
        check("rst_valid", 192'(out_valid), 192'(5'b00000));
        check("rst_cnt", 192'(err_cnt), 192'(0));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'd0, '0, 5'b11111, 1'b0);
            check("rst_no_deliver", 192'(out_valid), 192'(5'b00000));
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)),
                 32'($urandom()),
                 5'($urandom()),
                 1'($urandom_range(0, 199) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
